// File: rtl/ifmap_spad_ring.sv
// ifmap_spad_ring: circular ifmap scratchpad with offset reads, windowed release and occupancy flags.
module ifmap_spad_ring #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              rel_en,
  input  logic [AW:0]       rel_cnt,
  output logic              rel_err,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, rd_addr;
  logic [AW:0] count_q, count_d, rel_eff;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, rel_err_q, rel_err_d;
  logic push_acc, resident;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign wr_ready = !full;
  assign count = count_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err = rd_err_q;
  assign rel_err = rel_err_q;
  assign push_acc = wr_valid && !full;
  assign resident = {1'b0, rd_offset} < count_q;
  assign rd_addr = head_q + rd_offset;
  // Releases are clamped to occupancy so count can never underflow.
  assign rel_eff = !rel_en ? '0 : (rel_cnt > count_q ? count_q : rel_cnt);
  always_comb begin
    head_d = clr ? '0 : head_q + rel_eff[AW-1:0];
    tail_d = clr ? '0 : tail_q + AW'(push_acc);
    count_d = clr ? '0 : count_q + (AW+1)'(push_acc) - rel_eff;
    rd_valid_d = !clr && rd_en;
    rd_err_d = !clr && rd_en && !resident;
    rd_data_d = (!clr && rd_en && resident) ? mem[rd_addr] : '0;
    rel_err_d = !clr && rel_en && (rel_cnt > count_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q <= 1'b0;
      rel_err_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q <= rd_err_d;
      rel_err_q <= rel_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_acc && !clr && !rst) mem[tail_q] <= wr_data;
  end
endmodule

// File: tb/tb_ifmap_spad_ring.sv
// tb_ifmap_spad_ring: directed and randomized checks of ifmap_spad_ring against a queue model.
module tb_ifmap_spad_ring;
  localparam int DW = 8;
  localparam int D = 8;
  logic clk = 0, rst = 1, clr = 0, wr_valid = 0, rd_en = 0, rel_en = 0;
  logic wr_ready, rd_valid, rd_err, rel_err, full, empty;
  logic [DW-1:0] wr_data = 0, rd_data;
  logic [2:0] rd_offset = 0;
  logic [3:0] rel_cnt = 0, count;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] e_rdd;
  logic e_rdv, e_rde, e_rele;

  ifmap_spad_ring #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_en(rd_en), .rd_offset(rd_offset), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .rel_en(rel_en), .rel_cnt(rel_cnt),
    .rel_err(rel_err), .count(count), .full(full), .empty(empty));

  always #5 clk = ~clk;

  task automatic idle();
    clr = 0; wr_valid = 0; rd_en = 0; rel_en = 0; rd_offset = 0; rel_cnt = 0; wr_data = 0;
  endtask

  // Model step: expectations are formed from the queue before the edge, then the queue is updated.
  task automatic tick();
    int n;
    if (clr) begin
      q.delete(); e_rdv = 0; e_rde = 0; e_rdd = 0; e_rele = 0;
    end else begin
      e_rdv = rd_en;
      e_rde = rd_en && int'(rd_offset) >= q.size();
      e_rdd = (rd_en && int'(rd_offset) < q.size()) ? q[rd_offset] : 8'h00;
      e_rele = rel_en && int'(rel_cnt) > q.size();
      n = !rel_en ? 0 : (int'(rel_cnt) > q.size() ? q.size() : int'(rel_cnt));
      if (wr_valid && q.size() < D) begin
        for (int i = 0; i < n; i++) void'(q.pop_front());
        q.push_back(wr_data);
      end else
        for (int i = 0; i < n; i++) void'(q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] v);
    idle(); wr_valid = 1; wr_data = v; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; #2;
    total++; if (count !== 0 || !empty || full || !wr_ready) begin bad++;
      $display("FAIL reset_flags: count=%0d empty=%b full=%b wr_ready=%b want 0 1 0 1", count, empty, full, wr_ready); end
    total++; if (rd_valid !== 0 || rd_err !== 0 || rel_err !== 0 || rd_data !== 0) begin bad++;
      $display("FAIL reset_regs: rd_valid=%b rd_err=%b rel_err=%b rd_data=%h want all 0", rd_valid, rd_err, rel_err, rd_data); end
    @(negedge clk); rst = 0; q.delete(); @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i));
      total++; if (count !== 4'(i + 1)) begin bad++;
        $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
    end
    total++; if (wr_ready !== 0 || full !== 1) begin bad++;
      $display("FAIL fill_full: wr_ready=%b full=%b want 0 1", wr_ready, full); end
    push(8'h99);
    total++; if (count !== 8 || q.size() != 8) begin bad++;
      $display("FAIL push_at_full: count=%0d want 8", count); end
  endtask

  task automatic test_read();
    logic [7:0] want [3] = '{8'h10, 8'h13, 8'h17};
    logic [2:0] offs [3] = '{3'd0, 3'd3, 3'd7};
    for (int i = 0; i < 3; i++) begin
      idle(); rd_en = 1; rd_offset = offs[i]; tick();
      total++; if (rd_data !== want[i] || rd_valid !== 1 || rd_err !== 0) begin bad++;
        $display("FAIL read_off%0d: data=%h v=%b e=%b want %h 1 0", offs[i], rd_data, rd_valid, rd_err, want[i]); end
    end
    idle(); tick();
    total++; if (rd_valid !== 0 || rd_data !== 0) begin bad++;
      $display("FAIL read_idle: v=%b data=%h want 0 00", rd_valid, rd_data); end
  endtask

  task automatic test_release_read();
    idle(); rel_en = 1; rel_cnt = 3; rd_en = 1; rd_offset = 0; tick();
    total++; if (rd_data !== 8'h10 || count !== 5 || rel_err !== 0) begin bad++;
      $display("FAIL rel_read_same: data=%h count=%0d rel_err=%b want 10 5 0", rd_data, count, rel_err); end
    idle(); rd_en = 1; rd_offset = 0; tick();
    total++; if (rd_data !== 8'h13) begin bad++;
      $display("FAIL rel_read_next: data=%h want 13", rd_data); end
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
    idle(); rd_en = 1; rd_offset = 7; tick();
    total++; if (rd_data !== 8'hA2 || rd_err !== 0 || count !== 8) begin bad++;
      $display("FAIL wrap_read: data=%h err=%b count=%0d want a2 0 8", rd_data, rd_err, count); end
  endtask

  task automatic test_over_release();
    idle(); rel_en = 1; rel_cnt = 3; tick();
    idle(); rel_en = 1; rel_cnt = 7; tick();
    total++; if (rel_err !== 1 || count !== 0 || empty !== 1) begin bad++;
      $display("FAIL over_release: rel_err=%b count=%0d empty=%b want 1 0 1", rel_err, count, empty); end
    idle(); rd_en = 1; rd_offset = 0; tick();
    total++; if (rel_err !== 0 || rd_data !== 0 || rd_err !== 1 || rd_valid !== 1) begin bad++;
      $display("FAIL empty_read: rel_err=%b data=%h rd_err=%b v=%b want 0 00 1 1", rel_err, rd_data, rd_err, rd_valid); end
  endtask

  task automatic test_full_push_release();
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    idle(); wr_valid = 1; wr_data = 8'h55; rel_en = 1; rel_cnt = 2; tick();
    total++; if (count !== 6) begin bad++;
      $display("FAIL full_push_rel: count=%0d want 6", count); end
    push(8'h55);
    total++; if (count !== 7) begin bad++;
      $display("FAIL push_after_rel: count=%0d want 7", count); end
    idle(); rd_en = 1; rd_offset = 6; tick();
    total++; if (rd_data !== 8'h55 || rd_data !== e_rdd) begin bad++;
      $display("FAIL pushed_word: data=%h want 55", rd_data); end
  endtask

  task automatic test_async_reset();
    idle(); rst = 1; #2; rst = 0; q.delete(); @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    idle(); rd_en = 1; rd_offset = 1; tick();
    #3 rst = 1; #1;
    total++; if (count !== 0 || rd_valid !== 0 || rd_data !== 0 || !empty) begin bad++;
      $display("FAIL async_rst: count=%0d v=%b data=%h empty=%b want 0 0 00 1", count, rd_valid, rd_data, empty); end
    #1 rst = 0; q.delete(); idle(); tick();
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    idle(); rd_en = 1; rd_offset = 1; tick();
    clr = 1; wr_valid = 1; wr_data = 8'hEE; rel_en = 1; rel_cnt = 2; rd_en = 1; rd_offset = 0; tick(); idle();
    total++; if (count !== 0 || rd_valid !== 0 || rd_data !== 0 || rd_err !== 0 || rel_err !== 0 || !empty) begin bad++;
      $display("FAIL clr: count=%0d v=%b data=%h rd_err=%b rel_err=%b want 0 0 00 0 0", count, rd_valid, rd_data, rd_err, rel_err); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 60) == 0);
      wr_valid = $urandom_range(0, 2) != 0; wr_data = 8'($urandom);
      rd_en = $urandom_range(0, 1) != 0; rd_offset = 3'($urandom);
      rel_en = $urandom_range(0, 3) == 0; rel_cnt = 4'($urandom_range(0, 8));
      tick();
      total++; if (rd_data !== e_rdd || rd_valid !== e_rdv || rd_err !== e_rde || rel_err !== e_rele) begin bad++;
        $display("FAIL rand_rd c=%0d: data=%h v=%b e=%b rel_err=%b want %h %b %b %b", c, rd_data, rd_valid, rd_err, rel_err, e_rdd, e_rdv, e_rde, e_rele); end
      total++; if (count !== 4'(q.size()) || full !== (q.size() == D) || empty !== (q.size() == 0)) begin bad++;
        $display("FAIL rand_count c=%0d: count=%0d full=%b empty=%b want %0d", c, count, full, empty, q.size()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read();
    test_release_read();
    test_over_release();
    test_full_push_release();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifmap_spad_ring.md
Name: ifmap_spad_ring

Overview:
Parametrised input-feature-map scratchpad for the PE, organised as a circular buffer with sliding-window reuse. The upstream NoC/GLB pushes ifmap words through a valid/ready handshake. The MAC datapath reads any resident word by offset from the oldest entry, then releases a stride's worth of old words to advance the window. It replaces the fixed 64x8 addressed scratchpad and adds flow control, occupancy tracking, registered reads and error flags.

Parameters:
DATA_W, 8, ifmap word width in bits (>=1)
DEPTH, 64, number of entries; power of two, >=2
AW, $clog2(DEPTH), offset/pointer width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush; empties buffer
wr_valid  input  1  push request
wr_ready  output  1  buffer can accept a push (= !full)
wr_data  input  DATA_W  word to push
rd_en  input  1  read request
rd_offset  input  AW  offset from head (0 = oldest resident word)
rd_data  output  DATA_W  registered read data
rd_valid  output  1  rd_data valid, one cycle after rd_en
rd_err  output  1  pulse: previous read offset was not resident
rel_en  input  1  release request
rel_cnt  input  AW+1  number of oldest words to release (0..DEPTH)
rel_err  output  1  pulse: previous release exceeded occupancy
count  output  AW+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst=1, asynchronous): head, tail and count = 0. rd_data = 0, rd_valid = 0, rd_err = 0, rel_err = 0. Resulting combinational outputs: full = 0, empty = 1, wr_ready = 1. Storage array is not cleared; reads of non-resident entries are masked (below). A reset mid-operation discards all content and any in-flight read result.
- clr=1 at a clock edge: same register effect as reset. Overrides push, read and release in that cycle.
- Push: accepted when wr_valid & wr_ready. Writes mem[tail], tail <= tail+1 mod DEPTH. wr_ready depends only on the current count, never on a same-cycle release. wr_valid while full is ignored: no write, no error.
- Read: rd_en sampled at edge N; rd_data/rd_valid update at edge N (visible in cycle N+1), i.e. 1-cycle latency.
  - Resident (rd_offset < count, pre-update state): rd_data <= mem[(head+rd_offset) mod DEPTH], rd_valid <= 1, rd_err <= 0.
  - Non-resident: rd_data <= 0, rd_valid <= 1, rd_err <= 1.
  - rd_en=0: rd_valid <= 0, rd_err <= 0, rd_data <= 0.
- Release: when rel_en, rel_eff = min(rel_cnt, count) using pre-update count. head <= head+rel_eff mod DEPTH. rel_err <= (rel_cnt > count). rel_cnt = 0 is a legal no-op. rel_err <= 0 when rel_en=0.
- Same-cycle events: all decisions use the pre-edge state.
  - count_next = count + push_acc - rel_eff.
  - A word pushed this cycle is neither readable nor releasable until the next cycle.
  - A read in the same cycle as a release returns data relative to the old head.
  - Push at full with a simultaneous release: push is refused (wr_ready = 0).
- Wrap-around: head and tail roll over modulo DEPTH. Offset addition wraps the same way. count saturates naturally in 0..DEPTH because pushes are gated by full and releases are clamped.
- No combinational path from inputs to outputs except wr_ready/full/empty, which are derived from registered count.

Test Plan (DEPTH=8, DATA_W=8):
1. Reset, then push 0x10..0x17 back-to-back -> wr_ready drops after the 8th accept, full=1, count=8. A 9th push with wr_valid=1 is not written and count stays 8.
2. Read offsets 0,3,7 in consecutive cycles -> rd_data 0x10, 0x13, 0x17 each one cycle later, rd_valid=1, rd_err=0. Then rd_en=0 -> rd_valid=0, rd_data=0.
3. Release 3 and in the same cycle read offset 0 -> read returns 0x10, count=5. Next read offset 0 returns 0x13. Push 0xA0..0xA2 -> tail wraps. Read offset 7 returns 0xA2.
4. With count=5, release rel_cnt=7 -> rel_err pulses one cycle, count=0, empty=1. Read offset 0 -> rd_data=0, rd_err=1.
5. At full (count=8), push 0x55 with release 2 in the same cycle -> push refused, count=6. Next cycle push accepted, count=7.
6. Mid-stream with count=4 and rd_en=1, assert rst asynchronously between edges -> outputs clear immediately, count=0, rd_valid=0. Repeat the same case with clr=1 -> identical result at the next edge, with push/read/release in that cycle ignored.
